// File: rtl/line_pkg.sv
// Shared types and constants for the keyboard line assembler.
package line_pkg;
  typedef enum logic {EDIT = 1'b0, HOLD = 1'b1} state_t;

  localparam int CHAR_PRINT_MIN    = 32;
  localparam int CHAR_PRINT_MAX    = 126;
  localparam int MAX_CHARS_DEFAULT = 32;
  localparam int CHAR_W_DEFAULT    = 8;
endpackage

// File: rtl/line_event_arbiter.sv
// Combinational keystroke arbiter: enter > bksp > key, printable/capacity check, drop flag.
// Zero latency; while not editing every incoming event is flagged as dropped.
module line_event_arbiter
  import line_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEFAULT,
  parameter int CHAR_W    = CHAR_W_DEFAULT,
  parameter int CW        = $clog2(MAX_CHARS + 1)
) (
  input  logic              i_edit,
  input  logic              i_key,
  input  logic              i_enter,
  input  logic              i_bksp,
  input  logic [CHAR_W-1:0] i_char,
  input  logic [CW-1:0]     i_cursor,
  output logic              o_do_key,
  output logic              o_do_bksp,
  output logic              o_do_enter,
  output logic              o_drop
);
  logic [15:0] w_code;
  logic        w_printable;
  logic        w_empty;
  logic        w_full;

  assign w_code      = 16'(i_char);
  assign w_printable = (w_code >= 16'(CHAR_PRINT_MIN)) && (w_code <= 16'(CHAR_PRINT_MAX));
  assign w_empty     = (i_cursor == '0);
  assign w_full      = (i_cursor == CW'(MAX_CHARS));

  always_comb begin
    o_do_key   = 1'b0;
    o_do_bksp  = 1'b0;
    o_do_enter = 1'b0;
    o_drop     = 1'b0;
    if (!i_edit) begin
      o_drop = i_key | i_enter | i_bksp;
    end else if (i_enter) begin
      // Enter on an empty line is ignored, but coinciding events still lose.
      o_do_enter = !w_empty;
      o_drop     = i_key | i_bksp;
    end else if (i_bksp) begin
      o_do_bksp = !w_empty;
      o_drop    = i_key;
    end else if (i_key) begin
      o_do_key = w_printable && !w_full;
      o_drop   = !(w_printable && !w_full);
    end
  end
endmodule

// File: rtl/line_assembler.sv
// Builds a text line from keystroke pulses; presents it via valid/ready, edits blocked until accepted.
// 1-cycle event latency; optional display echo outputs under LINE_ASSEMBLER_ECHO_EN.
module line_assembler
  import line_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEFAULT,
  parameter int CHAR_W    = CHAR_W_DEFAULT
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           key_pressed,
  input  logic                           enter_pressed,
  input  logic                           bksp_pressed,
  input  logic [15:0]                    character,
  output logic                           line_valid,
  input  logic                           line_ready,
  output logic [MAX_CHARS*CHAR_W-1:0]    line_data,
  output logic [$clog2(MAX_CHARS+1)-1:0] line_len,
  output logic [$clog2(MAX_CHARS+1)-1:0] cursor_pos,
  output logic                           buf_full,
  output logic                           drop_pulse
`ifdef LINE_ASSEMBLER_ECHO_EN
  ,
  output logic                           echo_valid,
  output logic [CHAR_W-1:0]              echo_char,
  output logic [$clog2(MAX_CHARS+1)-1:0] echo_pos,
  output logic                           echo_erase
`endif
);
  localparam int CW = $clog2(MAX_CHARS + 1);

  state_t            r_state;
  logic [CHAR_W-1:0] r_buf [MAX_CHARS];
  logic [CW-1:0]     r_cursor;
  logic [CW-1:0]     r_len;
  logic              r_valid;
  logic              r_drop;

  logic              w_do_key;
  logic              w_do_bksp;
  logic              w_do_enter;
  logic              w_drop;
  logic [CHAR_W-1:0] w_char;
  logic              w_unused_char;

  assign w_char        = character[CHAR_W-1:0];
  assign w_unused_char = ^character;

  line_event_arbiter #(
    .MAX_CHARS (MAX_CHARS),
    .CHAR_W    (CHAR_W),
    .CW        (CW)
  ) u_arb (
    .i_edit     (r_state == EDIT),
    .i_key      (key_pressed),
    .i_enter    (enter_pressed),
    .i_bksp     (bksp_pressed),
    .i_char     (w_char),
    .i_cursor   (r_cursor),
    .o_do_key   (w_do_key),
    .o_do_bksp  (w_do_bksp),
    .o_do_enter (w_do_enter),
    .o_drop     (w_drop)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= EDIT;
      r_cursor <= '0;
      r_len    <= '0;
      r_valid  <= 1'b0;
      r_drop   <= 1'b0;
      for (int i = 0; i < MAX_CHARS; i++) r_buf[i] <= '0;
    end else begin
      r_drop <= w_drop;
      case (r_state)
        EDIT: begin
          if (w_do_enter) begin
            r_len   <= r_cursor;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else if (w_do_bksp) begin
            r_cursor <= r_cursor - CW'(1);
            for (int i = 0; i < MAX_CHARS; i++)
              if (r_cursor == CW'(i + 1)) r_buf[i] <= '0;
          end else if (w_do_key) begin
            r_cursor <= r_cursor + CW'(1);
            for (int i = 0; i < MAX_CHARS; i++)
              if (r_cursor == CW'(i)) r_buf[i] <= w_char;
          end
        end
        HOLD: begin
          // Buffer doubles as the presented line, so acceptance wipes it for the next edit.
          if (line_ready) begin
            r_valid  <= 1'b0;
            r_cursor <= '0;
            r_state  <= EDIT;
            for (int i = 0; i < MAX_CHARS; i++) r_buf[i] <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    line_data = '0;
    for (int i = 0; i < MAX_CHARS; i++) line_data[i*CHAR_W +: CHAR_W] = r_buf[i];
  end

  assign line_valid = r_valid;
  assign line_len   = r_len;
  assign cursor_pos = r_cursor;
  assign buf_full   = (r_cursor == CW'(MAX_CHARS));
  assign drop_pulse = r_drop;

`ifdef LINE_ASSEMBLER_ECHO_EN
  logic              r_echo_valid;
  logic [CHAR_W-1:0] r_echo_char;
  logic [CW-1:0]     r_echo_pos;
  logic              r_echo_erase;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_echo_valid <= 1'b0;
      r_echo_char  <= '0;
      r_echo_pos   <= '0;
      r_echo_erase <= 1'b0;
    end else begin
      r_echo_valid <= w_do_key | w_do_bksp;
      r_echo_char  <= w_do_key ? w_char : '0;
      r_echo_pos   <= w_do_key ? r_cursor : (w_do_bksp ? r_cursor - CW'(1) : '0);
      r_echo_erase <= w_do_bksp;
    end
  end

  assign echo_valid = r_echo_valid;
  assign echo_char  = r_echo_char;
  assign echo_pos   = r_echo_pos;
  assign echo_erase = r_echo_erase;
`endif
endmodule

// File: tb/tb_line_assembler.sv
// Directed bench for line_assembler (MAX_CHARS=4); finished lines checked through a scoreboard queue.
module tb_line_assembler;
  localparam int MC = 4;
  localparam int CWB = 8;
  localparam int LW = $clog2(MC + 1);

  typedef struct {
    logic [MC*CWB-1:0] data;
    logic [LW-1:0]     len;
  } line_t;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              key_pressed = 1'b0;
  logic              enter_pressed = 1'b0;
  logic              bksp_pressed = 1'b0;
  logic [15:0]       character = '0;
  logic              line_valid;
  logic              line_ready = 1'b0;
  logic [MC*CWB-1:0] line_data;
  logic [LW-1:0]     line_len;
  logic [LW-1:0]     cursor_pos;
  logic              buf_full;
  logic              drop_pulse;
`ifdef LINE_ASSEMBLER_ECHO_EN
  logic              echo_valid;
  logic [CWB-1:0]    echo_char;
  logic [LW-1:0]     echo_pos;
  logic              echo_erase;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  line_t sb_q[$];

  always #5 clk_in = ~clk_in;

  line_assembler #(.MAX_CHARS(MC), .CHAR_W(CWB)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .key_pressed   (key_pressed),
    .enter_pressed (enter_pressed),
    .bksp_pressed  (bksp_pressed),
    .character     (character),
    .line_valid    (line_valid),
    .line_ready    (line_ready),
    .line_data     (line_data),
    .line_len      (line_len),
    .cursor_pos    (cursor_pos),
    .buf_full      (buf_full),
    .drop_pulse    (drop_pulse)
`ifdef LINE_ASSEMBLER_ECHO_EN
    ,
    .echo_valid    (echo_valid),
    .echo_char     (echo_char),
    .echo_pos      (echo_pos),
    .echo_erase    (echo_erase)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic press_key(input logic [15:0] c);
    key_pressed = 1'b1;
    character   = c;
    tick();
    key_pressed = 1'b0;
  endtask

  task automatic press_bksp();
    bksp_pressed = 1'b1;
    tick();
    bksp_pressed = 1'b0;
  endtask

  task automatic press_enter();
    enter_pressed = 1'b1;
    tick();
    enter_pressed = 1'b0;
  endtask

  task automatic expect_line(input logic [31:0] d, input logic [LW-1:0] l);
    line_t e;
    e.data = d;
    e.len  = l;
    sb_q.push_back(e);
  endtask

  // Monitor: every handshake must match the oldest expected line.
  always @(negedge clk_in) begin
    if (!rst_in && line_valid && line_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_line", 32'(line_len), 32'hFFFF_FFFF);
      end else begin
        line_t e;
        e = sb_q.pop_front();
        chk("sb_line_data", line_data, e.data);
        chk("sb_line_len", 32'(line_len), 32'(e.len));
      end
    end
  end

  initial begin
    tick();
    tick();
    rst_in = 1'b0;
    chk("rst_valid", 32'(line_valid), 0);
    chk("rst_cursor", 32'(cursor_pos), 0);
    chk("rst_len", 32'(line_len), 0);
    chk("rst_drop", 32'(drop_pulse), 0);
    chk("rst_data", line_data, 0);

    // "abc"
    press_key(16'd97);  chk("abc_cur1", 32'(cursor_pos), 1);
    press_key(16'd98);  chk("abc_cur2", 32'(cursor_pos), 2);
    press_key(16'd99);  chk("abc_cur3", 32'(cursor_pos), 3);
    chk("abc_not_valid_yet", 32'(line_valid), 0);
    expect_line(32'h0063_6261, 3);
    press_enter();
    chk("abc_valid", 32'(line_valid), 1);
    chk("abc_len", 32'(line_len), 3);
    chk("abc_data", line_data, 32'h0063_6261);
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    chk("abc_after_valid", 32'(line_valid), 0);
    chk("abc_after_cursor", 32'(cursor_pos), 0);

    // "xz" with ready held high throughout editing
    line_ready = 1'b1;
    press_key(16'd120);
    press_key(16'd121);
    press_bksp();       chk("xz_bksp_cur", 32'(cursor_pos), 1);
    chk("xz_bksp_data", line_data, 32'h0000_0078);
    press_key(16'd122); chk("xz_cur", 32'(cursor_pos), 2);
    expect_line(32'h0000_7A78, 2);
    press_enter();
    chk("xz_valid", 32'(line_valid), 1);
    tick();
    line_ready = 1'b0;
    chk("xz_after_valid", 32'(line_valid), 0);
    chk("xz_after_cursor", 32'(cursor_pos), 0);
    chk("xz_after_data", line_data, 0);

    // Capacity: '1'..'5' into a 4-slot buffer
    press_key(16'h31);
    press_key(16'h32);
    press_key(16'h33);  chk("cap_not_full", 32'(buf_full), 0);
    press_key(16'h34);  chk("cap_full", 32'(buf_full), 1);
    chk("cap_drop4", 32'(drop_pulse), 0);
    press_key(16'h35);  chk("cap_drop5", 32'(drop_pulse), 1);
    chk("cap_cursor", 32'(cursor_pos), 4);
    chk("cap_data", line_data, 32'h3433_3231);
    expect_line(32'h3433_3231, 4);
    press_enter();
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    chk("cap_cleared", 32'(cursor_pos), 0);

    // Empty-line edits and printable boundaries
    press_bksp();
    chk("empty_bksp_drop", 32'(drop_pulse), 0);
    chk("empty_bksp_cur", 32'(cursor_pos), 0);
    press_enter();
    chk("empty_enter_drop", 32'(drop_pulse), 0);
    tick();
    chk("empty_enter_valid", 32'(line_valid), 0);
    press_key(16'h000A); chk("lf_drop", 32'(drop_pulse), 1);
    chk("lf_cursor", 32'(cursor_pos), 0);
    press_key(16'h0141); chk("hi_bits_cur", 32'(cursor_pos), 1);
    press_key(16'h0020); chk("space_cur", 32'(cursor_pos), 2);
    press_key(16'h007E); chk("tilde_cur", 32'(cursor_pos), 3);
    press_key(16'h001F); chk("x1f_drop", 32'(drop_pulse), 1);
    press_key(16'h007F); chk("x7f_drop", 32'(drop_pulse), 1);
    chk("bound_cursor", 32'(cursor_pos), 3);
    chk("bound_data", line_data, 32'h007E_2041);

    // Hold with consumer stalled, then reset discards the line
    press_enter();
    repeat (10) tick();
    chk("hold_valid", 32'(line_valid), 1);
    press_key(16'd113);
    chk("hold_key_drop", 32'(drop_pulse), 1);
    chk("hold_len", 32'(line_len), 3);
    chk("hold_data", line_data, 32'h007E_2041);
    press_bksp();
    chk("hold_bksp_drop", 32'(drop_pulse), 1);
    chk("hold_bksp_data", line_data, 32'h007E_2041);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("hold_rst_valid", 32'(line_valid), 0);
    chk("hold_rst_cursor", 32'(cursor_pos), 0);
    chk("hold_rst_data", line_data, 0);

    // Key and enter together: enter wins
    press_key(16'd107);
    press_key(16'd109);
    expect_line(32'h0000_6D6B, 2);
    key_pressed   = 1'b1;
    enter_pressed = 1'b1;
    character     = 16'd110;
    tick();
    key_pressed   = 1'b0;
    enter_pressed = 1'b0;
    chk("coin_drop", 32'(drop_pulse), 1);
    chk("coin_valid", 32'(line_valid), 1);
    chk("coin_len", 32'(line_len), 2);
    chk("coin_cursor", 32'(cursor_pos), 2);
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    chk("coin_after_valid", 32'(line_valid), 0);

    // Bksp and key together: bksp wins
    press_key(16'd65);
    press_key(16'd66);
    key_pressed  = 1'b1;
    bksp_pressed = 1'b1;
    character    = 16'd67;
    tick();
    key_pressed  = 1'b0;
    bksp_pressed = 1'b0;
    chk("bk_key_drop", 32'(drop_pulse), 1);
    chk("bk_key_cursor", 32'(cursor_pos), 1);
    chk("bk_key_data", line_data, 32'h0000_0041);

    tick();
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_assembler.md
Name: line_assembler

Overview:
Sits directly downstream of the keyboard input buffer. Consumes its per-keystroke pulses (key, enter, backspace) and assembles them into a complete text line/instruction held in a register array. On enter, presents the finished line to the instruction consumer through a valid/ready handshake. Editing is blocked until the consumer accepts the line.

Parameters:
MAX_CHARS, 32, line capacity in characters (power of two not required, >=2)
CHAR_W, 8, bits stored per character (low CHAR_W bits of character input)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
key_pressed  input  1  one-cycle pulse, character valid
enter_pressed  input  1  one-cycle pulse, end of line
bksp_pressed  input  1  one-cycle pulse, delete last character
character  input  16  character code; only [CHAR_W-1:0] used
line_valid  output  1  completed line available
line_ready  input  1  consumer accepts line when high with line_valid
line_data  output  MAX_CHARS*CHAR_W  char i at [i*CHAR_W +: CHAR_W]; unused slots 0
line_len  output  $clog2(MAX_CHARS+1)  character count of presented line
cursor_pos  output  $clog2(MAX_CHARS+1)  number of chars currently in edit buffer
buf_full  output  1  cursor_pos == MAX_CHARS
drop_pulse  output  1  one-cycle pulse: an input event was discarded

Behaviour:
- Reset (sync, rst_in high at posedge): state EDIT, all buffer slots 0, cursor_pos 0, line_valid 0, line_len 0, drop_pulse 0. Reset mid-handshake discards the pending line with no acceptance.
- States: EDIT, HOLD.
- EDIT, per cycle, priority enter > bksp > key when pulses coincide; lower-priority events in the same cycle are dropped (drop_pulse=1).
- key_pressed: if character[CHAR_W-1:0] in 32..126 and cursor_pos<MAX_CHARS, write slot[cursor_pos], cursor_pos+1 next cycle. If full or non-printable: no write, drop_pulse=1.
- bksp_pressed: if cursor_pos>0, clear slot[cursor_pos-1] to 0, cursor_pos-1. At 0: ignored, no drop_pulse.
- enter_pressed: if cursor_pos>0, latch line_len=cursor_pos, go HOLD, line_valid=1 next cycle. If cursor_pos==0: ignored, stay EDIT.
- HOLD: line_valid=1, line_data/line_len stable. Any key/bksp/enter pulse dropped, drop_pulse=1. On line_valid&&line_ready: next cycle line_valid=0, all slots 0, cursor_pos 0, state EDIT. line_ready while not valid has no effect.
- Latency: keystroke to cursor_pos update 1 cycle; enter to line_valid 1 cycle; minimum accept-to-new-edit 1 cycle.
- line_data is driven directly from the buffer registers (no copy); it is valid only while line_valid.
- buf_full is combinational from cursor_pos.

Optional Feature:
LINE_ASSEMBLER_ECHO_EN: when defined, adds outputs echo_valid (1), echo_char (CHAR_W), echo_pos ($clog2(MAX_CHARS+1)), echo_erase (1) for the text display: one-cycle pulse the cycle after each accepted key (char, its slot index, erase=0) or accepted backspace (char 0, cleared slot index, erase=1). Reset value 0 for all. When undefined, ports and logic absent; core behaviour identical.

Decomposition:
- Package line_pkg: state enum (EDIT, HOLD), constants CHAR_PRINT_MIN=32, CHAR_PRINT_MAX=126, MAX_CHARS default.
- One natural sub-module: line_event_arbiter (combinational priority + printable check producing do_key/do_bksp/do_enter/drop). Buffer and FSM stay in top.

Test Plan:
- Reset then keys 'a'(97),'b'(98),'c'(99) then enter -> cursor_pos 1,2,3; line_valid=1 one cycle after enter, line_len=3, line_data[23:0]=0x636261.
- 'x','y', bksp, 'z', enter, line_ready held 1 -> line "xz", line_len=2; one cycle after accept line_valid=0, cursor_pos=0, line_data all 0.
- MAX_CHARS=4: five keys '1'..'5' -> buf_full=1 after 4th, 5th dropped with drop_pulse=1, slot contents "1234".
- Bksp at cursor 0 and enter at cursor 0 -> no state change, no line_valid, no drop_pulse; key 0x0A -> drop_pulse=1, cursor unchanged.
- In HOLD with line_ready=0 for 10 cycles, send key 'q' -> drop_pulse=1, line_data/line_len unchanged; assert rst_in in HOLD -> line_valid=0, cursor_pos=0 next cycle.
- key_pressed and enter_pressed same cycle with cursor_pos=2 -> enter taken, key dropped (drop_pulse=1), line_len=2.
